// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked adder/subtractor with start/done handshake (optional ACCUMULATE_EN)
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             op_sub,
    input  logic             signed_mode,
`ifdef ACCUMULATE_EN
    input  logic             acc_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow,
    output logic             overflow,
    output logic             err,
    output logic             done
);

    localparam int K    = WIDTH / CHUNK;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;

    // Operands must split into whole chunks.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("addsub_seq: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;          // B already inverted for subtraction
    logic              sub_q;
    logic              smode_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  result_q;
    logic              carry_out_q;
    logic              borrow_q;
    logic              overflow_q;
    logic              err_q;

    logic [WIDTH-1:0]  a_src;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    sum_d;
    logic              last_d;
    logic              carry_d;
    logic              borrow_d;
    logic              overflow_d;

    // Operand A source: live input, or the previous result when accumulating.
    always_comb begin
`ifdef ACCUMULATE_EN
        a_src = acc_sel ? result_q : a;
`else
        a_src = a;
`endif
    end

    // One chunk of the ripple sum plus the flags as they would be on the final chunk.
    always_comb begin
        a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
        sum_d      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_d     = (idx_q == IDXW'(K - 1));
        carry_d    = sum_d[CHUNK];
        borrow_d   = ~smode_q & sub_q & ~carry_d;
        // Sign of the result is the top bit of the final chunk sum.
        overflow_d = smode_q & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_d[CHUNK-1] != a_q[WIDTH-1]);
    end

    // Control FSM and datapath registers; flags only change on the last chunk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            smode_q     <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_src;
                        b_q     <= b ^ {WIDTH{op_sub}};
                        sub_q   <= op_sub;
                        smode_q <= signed_mode;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[int'(idx_q)*CHUNK +: CHUNK] <= sum_d[CHUNK-1:0];
                    carry_q <= carry_d;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_d) begin
                        carry_out_q <= carry_d;
                        borrow_q    <= borrow_d;
                        overflow_q  <= overflow_d;
                        err_q       <= borrow_d | overflow_d;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - directed self-checking bench for addsub_seq
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_sub;
    logic        signed_mode;
    logic        acc_sel;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        start0, start1, start2;

    logic        ready0, ready1, ready2;
    logic        done0, done1, done2;
    logic [15:0] res0, res1;
    logic [31:0] res2;
    logic        c0, c1, c2, bo0, bo1, bo2, ov0, ov1, ov2, er0, er1, er2;

    int          passed = 0;
    int          total  = 0;
    int          sel    = 0;
    int          cnt;
    logic        rdy_hi;

    logic        ready_s, done_s;
    logic [31:0] res_s;
    logic [3:0]  flags_s;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .reset(reset), .start(start0), .ready(ready0),
        .op_sub(op_sub), .signed_mode(signed_mode),
`ifdef ACCUMULATE_EN
        .acc_sel(acc_sel),
`endif
        .a(a32[15:0]), .b(b32[15:0]), .result(res0),
        .carry_out(c0), .borrow(bo0), .overflow(ov0), .err(er0), .done(done0)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .reset(reset), .start(start1), .ready(ready1),
        .op_sub(op_sub), .signed_mode(signed_mode),
`ifdef ACCUMULATE_EN
        .acc_sel(acc_sel),
`endif
        .a(a32[15:0]), .b(b32[15:0]), .result(res1),
        .carry_out(c1), .borrow(bo1), .overflow(ov1), .err(er1), .done(done1)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(8)) u2 (
        .clk(clk), .reset(reset), .start(start2), .ready(ready2),
        .op_sub(op_sub), .signed_mode(signed_mode),
`ifdef ACCUMULATE_EN
        .acc_sel(acc_sel),
`endif
        .a(a32), .b(b32), .result(res2),
        .carry_out(c2), .borrow(bo2), .overflow(ov2), .err(er2), .done(done2)
    );

    // Select which instance the tasks observe; flags packed {carry_out, borrow, overflow, err}.
    always_comb begin
        case (sel)
            1:       begin ready_s = ready1; done_s = done1; res_s = {16'h0, res1}; flags_s = {c1, bo1, ov1, er1}; end
            2:       begin ready_s = ready2; done_s = done2; res_s = res2;          flags_s = {c2, bo2, ov2, er2}; end
            default: begin ready_s = ready0; done_s = done0; res_s = {16'h0, res0}; flags_s = {c0, bo0, ov0, er0}; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one op on instance s, then wait (bounded) for done and check latency and ready.
    task automatic run_op(input int s, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic tsm, input int exp_lat, input string tag);
        sel = s;
        @(negedge clk);
        a32 = ta; b32 = tb; op_sub = ts; signed_mode = tsm;
        start0 = (s == 0); start1 = (s == 1); start2 = (s == 2);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        cnt = 0; rdy_hi = 1'b0;
        while (!done_s && cnt < 20) begin
            if (ready_s) rdy_hi = 1'b1;
            @(negedge clk);
            cnt++;
        end
        if (ready_s) rdy_hi = 1'b1;
        check({tag, " latency"}, 64'(cnt), 64'(exp_lat));
        check({tag, " ready low in op"}, 64'(rdy_hi), 64'd0);
    endtask

    task automatic check_out(input string tag, input logic [31:0] er, input logic [3:0] ef);
        check({tag, " result"}, 64'(res_s), 64'(er));
        check({tag, " flags"}, 64'(flags_s), 64'(ef));
    endtask

    task automatic check_after(input string tag);
        @(negedge clk);
        check({tag, " done pulse ends"}, 64'(done_s), 64'd0);
        check({tag, " ready back"}, 64'(ready_s), 64'd1);
    endtask

    initial begin
        reset = 1'b1; start0 = 0; start1 = 0; start2 = 0;
        op_sub = 0; signed_mode = 0; acc_sel = 0; a32 = '0; b32 = '0;
        #1;
        check("reset ready", 64'(ready0), 64'd1);
        check("reset done", 64'(done0), 64'd0);
        check("reset result", 64'(res0), 64'd0);
        check("reset flags", 64'({c0, bo0, ov0, er0}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Test 1: plain unsigned add
        run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 4, "t1");
        check_out("t1", 32'h5555, 4'b0000);
        check_after("t1");

        // Test 2: signed overflow on add
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b1, 4, "t2");
        check_out("t2", 32'h8000, 4'b0011);
        check_after("t2");

        // Test 3: unsigned borrow and wrap
        run_op(0, 32'h0000, 32'h0001, 1'b1, 1'b0, 4, "t3");
        check_out("t3", 32'hFFFF, 4'b0101);
        check_after("t3");

        // Unsigned add carry shows on carry_out only
        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 4, "ucarry");
        check_out("ucarry", 32'h0000, 4'b1000);
        check_after("ucarry");

        // Signed negative overflow
        run_op(0, 32'h8000, 32'h8000, 1'b0, 1'b1, 4, "negov");
        check_out("negov", 32'h0000, 4'b1011);
        check_after("negov");

        // Test 4: start held high; mode change mid-op affects only the next op
        sel = 0;
        @(negedge clk);
        a32 = 32'h8000; b32 = 32'h0001; op_sub = 1'b1; signed_mode = 1'b1; start0 = 1'b1;
        @(negedge clk);
        signed_mode = 1'b0;
        cnt = 0;
        while (!done0 && cnt < 20) begin @(negedge clk); cnt++; end
        check("t4a latency", 64'(cnt), 64'd4);
        check_out("t4a", 32'h7FFF, 4'b1011);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!done0 && cnt < 20);
        check("t4 op spacing", 64'(cnt), 64'd6);
        check_out("t4b", 32'h7FFF, 4'b1000);
        start0 = 1'b0;
        check_after("t4b");

        // Test 5: reset mid-run abandons the op
        @(negedge clk);
        a32 = 32'h1111; b32 = 32'h2222; op_sub = 1'b0; signed_mode = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5 async ready", 64'(ready0), 64'd1);
        check("t5 async outs", 64'({res0, c0, bo0, ov0, er0, done0}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0; rdy_hi = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done0) rdy_hi = 1'b1;
        end
        check("t5 no done", 64'(rdy_hi), 64'd0);
        check("t5 result held 0", 64'(res0), 64'd0);
        run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 4, "t5 rerun");
        check_out("t5 rerun", 32'h5555, 4'b0000);
        check_after("t5 rerun");

        // Single-chunk instance
        run_op(1, 32'h1234, 32'h4321, 1'b0, 1'b0, 1, "c16");
        check_out("c16", 32'h5555, 4'b0000);
        check_after("c16");

        // 32-bit, 8-bit chunks: carry ripples through every chunk
        run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4, "w32");
        check_out("w32", 32'h0000_0000, 4'b1000);
        check_after("w32");

`ifdef ACCUMULATE_EN
        // Test 6: accumulate chain
        acc_sel = 1'b0;
        run_op(0, 32'h0005, 32'h0003, 1'b0, 1'b0, 4, "acc1");
        check_out("acc1", 32'h0008, 4'b0000);
        acc_sel = 1'b1;
        run_op(0, 32'hDEAD, 32'h000A, 1'b0, 1'b0, 4, "acc2");
        check_out("acc2", 32'h0012, 4'b0000);
        run_op(0, 32'hBEEF, 32'h0014, 1'b1, 1'b0, 4, "acc3");
        check_out("acc3", 32'hFFFE, 4'b0101);
        acc_sel = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
